// File: rtl/btn_debounce_pkg.sv
// Shared project constants and helpers for the pushbutton debouncer.
package btn_debounce_pkg;

    // Board timing: 10 ms at a 100 MHz system clock.
    localparam int unsigned DEBOUNCE_10MS_100MHZ = 1000000;

    function automatic bit cnt_width_ok(input int unsigned width, input int unsigned stable);
        longint unsigned span;
        span = longint'(1) << width;
        return (span >= longint'(stable));
    endfunction

endpackage

// File: rtl/btn_debounce_sync_ff.sv
// Generic multi-stage synchroniser for a single asynchronous input bit.
module sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr <= '0;
        end else begin
            sr <= {sr[STAGES-2:0], d};
        end
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/btn_debounce.sv
// Pushbutton debouncer: synchronises btn_in, then accepts a level change only
// after it has held for STABLE_CNT consecutive cycles; flags edges with pulses.
module btn_debounce
    import btn_debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned STABLE_CNT  = DEBOUNCE_10MS_100MHZ,
    parameter int unsigned CNT_WIDTH   = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_rise,
    output logic btn_fall,
    output logic busy
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("btn_debounce: SYNC_STAGES must be 2..4");
    end
    if (STABLE_CNT < 2 || !cnt_width_ok(CNT_WIDTH, STABLE_CNT)) begin : g_bad_cnt
        $error("btn_debounce: STABLE_CNT must be >= 2 and fit in CNT_WIDTH bits");
    end

    typedef enum logic [1:0] {
        IDLE_LO,
        WAIT_HI,
        IDLE_HI,
        WAIT_LO
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CNT - 1);

    state_t               state;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 btn_s;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_in),
        .q     (btn_s)
    );

    // Outputs are set from the next state so they change on the same edge
    // as the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE_LO;
            cnt       <= '0;
            btn_level <= 1'b0;
            btn_rise  <= 1'b0;
            btn_fall  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            btn_rise <= 1'b0;
            btn_fall <= 1'b0;
            case (state)
                IDLE_LO: begin
                    if (btn_s) begin
                        state <= WAIT_HI;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                WAIT_HI: begin
                    if (!btn_s) begin
                        state <= IDLE_LO;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state     <= IDLE_HI;
                        cnt       <= '0;
                        busy      <= 1'b0;
                        btn_level <= 1'b1;
                        btn_rise  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                IDLE_HI: begin
                    if (!btn_s) begin
                        state <= WAIT_LO;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                WAIT_LO: begin
                    if (btn_s) begin
                        state <= IDLE_HI;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state     <= IDLE_LO;
                        cnt       <= '0;
                        busy      <= 1'b0;
                        btn_level <= 1'b0;
                        btn_fall  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE_LO;
                    cnt       <= '0;
                    busy      <= 1'b0;
                    btn_level <= 1'b0;
                end
            endcase
        end
    end

endmodule
